su4_dot_acc: RTL and testbench

Sequential dot-product stage wrapped around the 4x4 signed×unsigned multiplier. It accepts a stream of (signed 4-bit, unsigned 4-bit) operand pairs under valid/ready. It drives registered operands to an external combinational multiplier and consumes that multiplier's 8-bit signed product the following cycle. Each group of LEN consecutive products is accumulated and emitted as one ACC_W-bit signed result under valid/ready.

---
 rtl/su4_dot_acc_pkg.sv | 19 +
 rtl/su4_dot_acc_if.sv | 29 ++
 rtl/su4_dot_acc_acc_out.sv | 66 ++++++
 rtl/su4_dot_acc.sv | 86 ++++++++
 tb/tb_su4_dot_acc.sv | 206 ++++++++++++++++++++
 5 files changed

// File: rtl/su4_dot_acc_pkg.sv
// rtl/su4_dot_acc_pkg.sv - shared widths and helpers for the signed x unsigned dot-product stage
package su4_mac_pkg;

    localparam int OP_W   = 4;
    localparam int PROD_W = 8;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r++;
        return r;
    endfunction

    // Callers size-cast the 32-bit result down to their accumulator width.
    function automatic logic [31:0] ext_prod(input logic [PROD_W-1:0] p);
        return {{(32-PROD_W){p[PROD_W-1]}}, p};
    endfunction

endpackage

// File: rtl/su4_dot_acc_if.sv
// rtl/su4_dot_acc_if.sv - operand stream, multiplier link and result stream of the dot-product stage
interface su4_dot_acc_if #(
    parameter int ACC_W = 12
);
    import su4_mac_pkg::*;

    logic              clr;
    logic              in_valid;
    logic              in_ready;
    logic [OP_W-1:0]   in_s;
    logic [OP_W-1:0]   in_u;
    logic [OP_W-1:0]   mul_s;
    logic [OP_W-1:0]   mul_u;
    logic [PROD_W-1:0] mul_p;
    logic              out_valid;
    logic              out_ready;
    logic [ACC_W-1:0]  out_acc;

    modport master (
        output clr, in_valid, in_s, in_u, mul_p, out_ready,
        input  in_ready, mul_s, mul_u, out_valid, out_acc
    );

    modport slave (
        input  clr, in_valid, in_s, in_u, mul_p, out_ready,
        output in_ready, mul_s, mul_u, out_valid, out_acc
    );

endinterface

// File: rtl/su4_dot_acc_acc_out.sv
// rtl/su4_dot_acc_acc_out.sv - accumulator, result register and back-pressure for the dot-product stage
module su4_acc_out
    import su4_mac_pkg::*;
#(
    parameter int ACC_W = 12
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr_i,
    input  logic              op_v_i,
    input  logic              op_last_i,
    input  logic [PROD_W-1:0] mul_p_i,
    input  logic              out_ready_i,
    output logic              stall_o,
    output logic              out_valid_o,
    output logic [ACC_W-1:0]  out_acc_o
);

    logic [ACC_W-1:0] acc_q, acc_d;
    logic [ACC_W-1:0] out_acc_q, out_acc_d;
    logic             out_valid_q, out_valid_d;
    logic [ACC_W-1:0] sum;
    logic             stall, consume, load;

    // Only a group's final product can be blocked; partial sums keep flowing.
    assign stall   = op_v_i & op_last_i & out_valid_q & ~out_ready_i;
    assign consume = op_v_i & ~stall;
    assign load    = consume & op_last_i;
    assign sum     = acc_q + ACC_W'(ext_prod(mul_p_i));

    always_comb begin
        acc_d       = acc_q;
        out_acc_d   = out_acc_q;
        out_valid_d = out_valid_q;
        if (clr_i) begin
            acc_d       = '0;
            out_acc_d   = '0;
            out_valid_d = 1'b0;
        end else begin
            if (consume) acc_d = op_last_i ? '0 : sum;
            if (load) begin
                out_acc_d   = sum;
                out_valid_d = 1'b1;
            end else if (out_ready_i) begin
                out_valid_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q       <= '0;
            out_acc_q   <= '0;
            out_valid_q <= 1'b0;
        end else begin
            acc_q       <= acc_d;
            out_acc_q   <= out_acc_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign stall_o     = stall;
    assign out_valid_o = out_valid_q;
    assign out_acc_o   = out_acc_q;

endmodule

// File: rtl/su4_dot_acc.sv
// rtl/su4_dot_acc.sv - streams operand pairs to an external 4x4 multiplier and sums LEN products per result
module su4_dot_acc
    import su4_mac_pkg::*;
#(
    parameter int LEN   = 8,
    parameter int ACC_W = 12
) (
    input  logic clk,
    input  logic rst_n,
    su4_dot_acc_if.slave bus
);

    localparam int               CNT_W    = (LEN > 1) ? clog2(LEN) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LEN - 1);

    logic [CNT_W-1:0] in_cnt_q, in_cnt_d;
    logic [OP_W-1:0]  mul_s_q, mul_s_d;
    logic [OP_W-1:0]  mul_u_q, mul_u_d;
    logic             op_v_q, op_v_d;
    logic             op_last_q, op_last_d;
    logic             stall, accept;
    logic             out_valid;
    logic [ACC_W-1:0] out_acc;

    assign accept = bus.in_valid & ~stall;

    always_comb begin
        in_cnt_d  = in_cnt_q;
        mul_s_d   = mul_s_q;
        mul_u_d   = mul_u_q;
        op_v_d    = op_v_q;
        op_last_d = op_last_q;
        if (bus.clr) begin
            in_cnt_d  = '0;
            op_v_d    = 1'b0;
            op_last_d = 1'b0;
        end else if (!stall) begin
            // Stage 2 drains op_v every unstalled cycle, so it only survives a refill.
            op_v_d = accept;
            if (accept) begin
                mul_s_d   = bus.in_s;
                mul_u_d   = bus.in_u;
                op_last_d = (in_cnt_q == CNT_LAST);
                in_cnt_d  = (in_cnt_q == CNT_LAST) ? '0 : in_cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            in_cnt_q  <= '0;
            mul_s_q   <= '0;
            mul_u_q   <= '0;
            op_v_q    <= 1'b0;
            op_last_q <= 1'b0;
        end else begin
            in_cnt_q  <= in_cnt_d;
            mul_s_q   <= mul_s_d;
            mul_u_q   <= mul_u_d;
            op_v_q    <= op_v_d;
            op_last_q <= op_last_d;
        end
    end

    su4_acc_out #(
        .ACC_W(ACC_W)
    ) u_acc_out (
        .clk        (clk),
        .rst_n      (rst_n),
        .clr_i      (bus.clr),
        .op_v_i     (op_v_q),
        .op_last_i  (op_last_q),
        .mul_p_i    (bus.mul_p),
        .out_ready_i(bus.out_ready),
        .stall_o    (stall),
        .out_valid_o(out_valid),
        .out_acc_o  (out_acc)
    );

    assign bus.in_ready  = ~stall;
    assign bus.mul_s     = mul_s_q;
    assign bus.mul_u     = mul_u_q;
    assign bus.out_valid = out_valid;
    assign bus.out_acc   = out_acc;

endmodule

// File: tb/tb_su4_dot_acc.sv
// tb/tb_su4_dot_acc.sv - directed bench for su4_dot_acc with three parameterisations
module tb_su4_dot_acc;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   total = 0;
    int   bad = 0;

    always #5 clk = ~clk;

    su4_dot_acc_if #(.ACC_W(12)) ifa ();
    su4_dot_acc_if #(.ACC_W(12)) ifb ();
    su4_dot_acc_if #(.ACC_W(10)) ifc ();

    function automatic logic [7:0] mulf(input logic [3:0] s, input logic [3:0] u);
        logic signed [7:0] a;
        logic signed [7:0] b;
        a = {{4{s[3]}}, s};
        b = {4'b0000, u};
        return 8'(a * b);
    endfunction

    assign ifa.mul_p = mulf(ifa.mul_s, ifa.mul_u);
    assign ifb.mul_p = mulf(ifb.mul_s, ifb.mul_u);
    assign ifc.mul_p = mulf(ifc.mul_s, ifc.mul_u);

    su4_dot_acc #(.LEN(4), .ACC_W(12)) dut_a (.clk(clk), .rst_n(rst_n), .bus(ifa.slave));
    su4_dot_acc #(.LEN(2), .ACC_W(12)) dut_b (.clk(clk), .rst_n(rst_n), .bus(ifb.slave));
    su4_dot_acc #(.LEN(8), .ACC_W(10)) dut_c (.clk(clk), .rst_n(rst_n), .bus(ifc.slave));

    logic [11:0] qa[$];
    logic [11:0] qb[$];
    logic [9:0]  qc[$];

    always @(negedge clk) begin
        if (rst_n && ifa.out_valid && ifa.out_ready) qa.push_back(ifa.out_acc);
        if (rst_n && ifb.out_valid && ifb.out_ready) qb.push_back(ifb.out_acc);
        if (rst_n && ifc.out_valid && ifc.out_ready) qc.push_back(ifc.out_acc);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send_a(input logic [3:0] s, input logic [3:0] u);
        ifa.in_valid = 1'b1;
        ifa.in_s = s;
        ifa.in_u = u;
        step();
    endtask

    task automatic test_reset();
        repeat (2) step();
        total++; if (ifa.in_ready !== 1'b1) begin bad++; $display("FAIL rst_in_ready got=%0d want=1", ifa.in_ready); end
        total++; if (ifa.mul_s !== 4'd0) begin bad++; $display("FAIL rst_mul_s got=%0d want=0", ifa.mul_s); end
        total++; if (ifa.mul_u !== 4'd0) begin bad++; $display("FAIL rst_mul_u got=%0d want=0", ifa.mul_u); end
        total++; if (ifa.out_valid !== 1'b0) begin bad++; $display("FAIL rst_out_valid got=%0d want=0", ifa.out_valid); end
        total++; if (ifa.out_acc !== 12'd0) begin bad++; $display("FAIL rst_out_acc got=%0d want=0", ifa.out_acc); end
        rst_n = 1'b1;
        step();
        total++; if (ifb.out_valid !== 1'b0) begin bad++; $display("FAIL rst_b_out_valid got=%0d want=0", ifb.out_valid); end
        total++; if (ifc.in_ready !== 1'b1) begin bad++; $display("FAIL rst_c_in_ready got=%0d want=1", ifc.in_ready); end
    endtask

    task automatic test_basic();
        ifa.out_ready = 1'b1;
        for (int i = 0; i < 4; i++) send_a(4'h8, 4'hF);
        ifa.in_valid = 1'b0;
        @(negedge clk);
        total++; if (ifa.out_valid !== 1'b0) begin bad++; $display("FAIL basic_early_valid got=%0d want=0", ifa.out_valid); end
        @(negedge clk);
        total++; if (ifa.out_valid !== 1'b1) begin bad++; $display("FAIL basic_valid got=%0d want=1", ifa.out_valid); end
        total++; if (ifa.out_acc !== 12'hE20) begin bad++; $display("FAIL basic_acc got=%0h want=e20", ifa.out_acc); end
        @(negedge clk);
        total++; if (ifa.out_valid !== 1'b0) begin bad++; $display("FAIL basic_one_cycle got=%0d want=0", ifa.out_valid); end
        step();
    endtask

    task automatic test_back_to_back();
        int low;
        low = 0;
        qa.delete();
        for (int i = 0; i < 8; i++) begin
            ifa.in_valid = 1'b1;
            ifa.in_s = (i < 4) ? 4'd7 : 4'd1;
            ifa.in_u = (i < 4) ? 4'd15 : 4'd1;
            @(negedge clk);
            if (!ifa.in_ready) low++;
            step();
        end
        ifa.in_valid = 1'b0;
        repeat (4) step();
        total++; if (low !== 0) begin bad++; $display("FAIL b2b_in_ready_low got=%0d want=0", low); end
        total++; if (qa.size() !== 2) begin bad++; $display("FAIL b2b_count got=%0d want=2", qa.size()); end
        else begin
            total++; if (qa[0] !== 12'h1A4) begin bad++; $display("FAIL b2b_first got=%0d want=420", qa[0]); end
            total++; if (qa[1] !== 12'd4) begin bad++; $display("FAIL b2b_second got=%0d want=4", qa[1]); end
        end
    endtask

    task automatic test_stall();
        int   sent;
        logic exp_rdy;
        sent = 0;
        qb.delete();
        for (int k = 0; k < 12; k++) begin
            ifb.out_ready = (k >= 6);
            ifb.in_valid = (sent < 4);
            ifb.in_s = 4'd3;
            ifb.in_u = 4'd2;
            @(negedge clk);
            if (ifb.in_valid && ifb.in_ready) sent++;
            if (k < 10) begin
                exp_rdy = !(k == 4 || k == 5);
                total++; if (ifb.in_ready !== exp_rdy) begin bad++; $display("FAIL stall_in_ready k=%0d got=%0d want=%0d", k, ifb.in_ready, exp_rdy); end
            end
            if (k >= 3 && k <= 5) begin
                total++; if (ifb.out_valid !== 1'b1) begin bad++; $display("FAIL stall_hold_valid k=%0d got=%0d want=1", k, ifb.out_valid); end
                total++; if (ifb.out_acc !== 12'd12) begin bad++; $display("FAIL stall_hold_acc k=%0d got=%0d want=12", k, ifb.out_acc); end
            end
            step();
        end
        ifb.in_valid = 1'b0;
        total++; if (qb.size() !== 2) begin bad++; $display("FAIL stall_count got=%0d want=2", qb.size()); end
        else begin
            total++; if (qb[0] !== 12'd12) begin bad++; $display("FAIL stall_first got=%0d want=12", qb[0]); end
            total++; if (qb[1] !== 12'd12) begin bad++; $display("FAIL stall_second got=%0d want=12", qb[1]); end
        end
    endtask

    task automatic test_wrap();
        qc.delete();
        ifc.out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            ifc.in_valid = 1'b1;
            ifc.in_s = 4'h8;
            ifc.in_u = 4'hF;
            step();
        end
        ifc.in_valid = 1'b0;
        repeat (4) step();
        total++; if (qc.size() !== 1) begin bad++; $display("FAIL wrap_count got=%0d want=1", qc.size()); end
        else begin
            total++; if (qc[0] !== 10'd64) begin bad++; $display("FAIL wrap_acc got=%0d want=64", qc[0]); end
        end
    endtask

    task automatic test_clr();
        qa.delete();
        ifa.out_ready = 1'b1;
        for (int i = 0; i < 3; i++) send_a(4'd2, 4'd2);
        ifa.clr = 1'b1;
        send_a(4'd7, 4'd7);
        ifa.clr = 1'b0;
        for (int i = 0; i < 4; i++) send_a(4'd1, 4'd1);
        ifa.in_valid = 1'b0;
        repeat (5) step();
        total++; if (qa.size() !== 1) begin bad++; $display("FAIL clr_count got=%0d want=1", qa.size()); end
        else begin
            total++; if (qa[0] !== 12'd4) begin bad++; $display("FAIL clr_acc got=%0d want=4", qa[0]); end
        end
    endtask

    task automatic test_reset_mid();
        qa.delete();
        ifa.out_ready = 1'b1;
        for (int i = 0; i < 2; i++) send_a(4'd5, 4'd5);
        ifa.in_valid = 1'b0;
        total++; if (ifa.mul_s !== 4'd5) begin bad++; $display("FAIL rmid_pre_mul_s got=%0d want=5", ifa.mul_s); end
        #3;
        rst_n = 1'b0;
        #1;
        total++; if (ifa.in_ready !== 1'b1) begin bad++; $display("FAIL rmid_in_ready got=%0d want=1", ifa.in_ready); end
        total++; if (ifa.mul_s !== 4'd0) begin bad++; $display("FAIL rmid_mul_s got=%0d want=0", ifa.mul_s); end
        total++; if (ifa.mul_u !== 4'd0) begin bad++; $display("FAIL rmid_mul_u got=%0d want=0", ifa.mul_u); end
        total++; if (ifa.out_valid !== 1'b0) begin bad++; $display("FAIL rmid_out_valid got=%0d want=0", ifa.out_valid); end
        total++; if (ifa.out_acc !== 12'd0) begin bad++; $display("FAIL rmid_out_acc got=%0d want=0", ifa.out_acc); end
        #2;
        rst_n = 1'b1;
        step();
        for (int i = 0; i < 4; i++) send_a(4'd1, 4'd3);
        ifa.in_valid = 1'b0;
        repeat (4) step();
        total++; if (qa.size() !== 1) begin bad++; $display("FAIL rmid_count got=%0d want=1", qa.size()); end
        else begin
            total++; if (qa[0] !== 12'd12) begin bad++; $display("FAIL rmid_acc got=%0d want=12", qa[0]); end
        end
    endtask

    initial begin
        ifa.clr = 1'b0; ifa.in_valid = 1'b0; ifa.in_s = '0; ifa.in_u = '0; ifa.out_ready = 1'b0;
        ifb.clr = 1'b0; ifb.in_valid = 1'b0; ifb.in_s = '0; ifb.in_u = '0; ifb.out_ready = 1'b0;
        ifc.clr = 1'b0; ifc.in_valid = 1'b0; ifc.in_s = '0; ifc.in_u = '0; ifc.out_ready = 1'b0;
        test_reset();
        test_basic();
        test_back_to_back();
        test_stall();
        test_wrap();
        test_clr();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
